// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_types_pkg : shared RAM-port types and requester ids                  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  reqid_t;

    localparam reqid_t REQ_I0 = 2'd0;
    localparam reqid_t REQ_D0 = 2'd1;
    localparam reqid_t REQ_I1 = 2'd2;
    localparam reqid_t REQ_D1 = 2'd3;

    function automatic reqid_t onehot_to_id(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rr_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick : round-robin one-hot pick starting at ptr                       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic         valid
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_rot_oh;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign w_rot    = N'({vec, vec} >> ptr);
    assign w_rot_oh = w_rot & (~w_rot + N'(1));
    assign grant    = N'(({w_rot_oh, w_rot_oh} << ptr) >> N);
    assign valid    = |vec;

endmodule
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_rr_arbiter : shares one RAM port among I0/D0/I1/D1 with aging, lock  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ram_rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int              NREQ     = 4,
    parameter logic [NREQ-1:0] DMASK    = 4'b1010,
    parameter int              AGE_MAX  = 4,
    parameter int              LOCK_MAX = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req_ren,
    input  logic [NREQ-1:0]       req_wen,
    input  logic [NREQ-1:0]       req_lock,
    input  word_t [NREQ-1:0]      req_addr,
    input  word_t [NREQ-1:0]      req_store,
    output logic [NREQ-1:0]       req_wait,
    output word_t                 req_load,
    output logic                  ramREN,
    output logic                  ramWEN,
    output word_t                 ramaddr,
    output word_t                 ramstore,
    input  word_t                 ramload,
    input  ramstate_t             ramstate,
    output logic                  grant_vld,
    output reqid_t                grant_id
);

    localparam int AW = $clog2(AGE_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    arb_state_t      r_state;
    reqid_t          r_ptr;
    logic [LW-1:0]   r_lockcnt;

    logic [NREQ-1:0] w_active;
    logic [NREQ-1:0] w_aged_hit;
    logic [NREQ-1:0] w_aged_oh;
    logic [NREQ-1:0] w_data_gnt;
    logic [NREQ-1:0] w_inst_gnt;
    logic [NREQ-1:0] w_win_oh;
    logic            w_data_vld;
    logic            w_inst_vld;
    logic            w_pick;
    logic            w_own_active;
    reqid_t          w_win_id;

    assign w_active     = req_ren | req_wen;
    assign w_own_active = w_active[grant_id];
    assign req_load     = ramload;

    rr_pick #(.N(NREQ)) u_pick_data (
        .vec   (w_active & DMASK),
        .ptr   (r_ptr),
        .grant (w_data_gnt),
        .valid (w_data_vld)
    );

    rr_pick #(.N(NREQ)) u_pick_inst (
        .vec   (w_active & ~DMASK),
        .ptr   (r_ptr),
        .grant (w_inst_gnt),
        .valid (w_inst_vld)
    );

    // A fully aged instruction requester beats everything, lowest index first.
    assign w_aged_oh = w_aged_hit & (~w_aged_hit + NREQ'(1));

    always_comb begin
        w_win_oh = w_inst_gnt;
        if (|w_aged_hit) begin
            w_win_oh = w_aged_oh;
        end else if (w_data_vld) begin
            w_win_oh = w_data_gnt;
        end
    end

    assign w_win_id = onehot_to_id(w_win_oh);
    assign w_pick   = (r_state == ARB_IDLE) && ((|w_aged_hit) || w_data_vld || w_inst_vld);

    for (genvar i = 0; i < NREQ; i++) begin : g_age
        if (!DMASK[i]) begin : g_inst
            logic [AW-1:0] r_age;
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_age <= '0;
                end else if (!w_active[i]) begin
                    r_age <= '0;
                end else if (w_pick) begin
                    if (w_win_oh[i]) begin
                        r_age <= '0;
                    end else if (r_age != AW'(AGE_MAX)) begin
                        r_age <= r_age + AW'(1);
                    end
                end
            end
            assign w_aged_hit[i] = w_active[i] && (r_age == AW'(AGE_MAX));
        end else begin : g_data
            assign w_aged_hit[i] = 1'b0;
        end
    end

    always_comb begin
        req_wait = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (r_state == ARB_BUSY && w_own_active) begin
            ramWEN   = req_wen[grant_id];
            ramREN   = req_ren[grant_id] & ~req_wen[grant_id];
            ramaddr  = req_addr[grant_id];
            ramstore = req_store[grant_id];
            if (ramstate == ACCESS) begin
                req_wait[grant_id] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= ARB_IDLE;
            r_ptr     <= '0;
            r_lockcnt <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick) begin
                        r_state   <= ARB_BUSY;
                        grant_vld <= 1'b1;
                        grant_id  <= w_win_id;
                        r_lockcnt <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (!w_own_active) begin
                        r_state   <= ARB_IDLE;
                        grant_vld <= 1'b0;
                        r_lockcnt <= '0;
                    end else if (ramstate == ACCESS) begin
                        if (req_lock[grant_id] && (int'(r_lockcnt) + 1 < LOCK_MAX)) begin
                            r_lockcnt <= r_lockcnt + LW'(1);
                        end else begin
                            r_state   <= ARB_IDLE;
                            grant_vld <= 1'b0;
                            r_ptr     <= grant_id + reqid_t'(1);
                            r_lockcnt <= '0;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_rr_arbiter : directed self-checking bench for ram_rr_arbiter      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ram_rr_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  req_ren, req_wen, req_lock, req_wait;
    word_t [3:0] req_addr, req_store;
    word_t       req_load, ramaddr, ramstore, ramload;
    logic        ramREN, ramWEN, grant_vld;
    reqid_t      grant_id;
    ramstate_t   ramstate;

    int total = 0;
    int bad   = 0;

    ram_rr_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .grant_vld(grant_vld), .grant_id(grant_id)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        req_ren   = '0;
        req_wen   = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_store = '0;
        ramload   = '0;
        ramstate  = FREE;
    endtask

    task automatic do_reset;
        idle_inputs();
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        nRST = 1'b1;
        #2 nRST = 1'b0;
        #1;
        total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL reset_grant_vld got=%b want=0", grant_vld); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
        total++; if (req_wait !== 4'hF) begin bad++; $display("FAIL reset_req_wait got=%b want=1111", req_wait); end
        total++; if ({ramREN, ramWEN} !== 2'b00) begin bad++; $display("FAIL reset_ram_en got=%b want=00", {ramREN, ramWEN}); end
        total++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin bad++; $display("FAIL reset_ram_bus got=%h/%h want=0/0", ramaddr, ramstore); end
        step();
        nRST = 1'b1;
    endtask

    task automatic test_single_read;
        do_reset();
        req_ren[1]  = 1'b1;
        req_addr[1] = 32'h40;
        ramstate    = BUSY;
        @(negedge CLK);
        total++; if (ramREN !== 1'b0 || req_wait !== 4'hF) begin bad++; $display("FAIL read_idle_cycle got ren=%b wait=%b want ren=0 wait=1111", ramREN, req_wait); end
        step(); @(negedge CLK);
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin bad++; $display("FAIL read_busy_drive got ren=%b addr=%h want ren=1 addr=40", ramREN, ramaddr); end
        total++; if (grant_vld !== 1'b1 || grant_id !== REQ_D0) begin bad++; $display("FAIL read_grant got vld=%b id=%0d want vld=1 id=1", grant_vld, grant_id); end
        total++; if (req_wait !== 4'hF) begin bad++; $display("FAIL read_wait_busy1 got=%b want=1111", req_wait); end
        step(); @(negedge CLK);
        total++; if (req_wait !== 4'hF) begin bad++; $display("FAIL read_wait_busy2 got=%b want=1111", req_wait); end
        step();
        ramstate = ACCESS;
        ramload  = 32'hCAFE0001;
        @(negedge CLK);
        total++; if (req_wait !== 4'b1101) begin bad++; $display("FAIL read_wait_access got=%b want=1101", req_wait); end
        total++; if (req_load !== 32'hCAFE0001) begin bad++; $display("FAIL read_load_pass got=%h want=cafe0001", req_load); end
        step();
        idle_inputs();
        @(negedge CLK);
        total++; if (grant_vld !== 1'b0 || ramREN !== 1'b0 || req_wait !== 4'hF) begin bad++; $display("FAIL read_back_idle got vld=%b ren=%b wait=%b want 0 0 1111", grant_vld, ramREN, req_wait); end
    endtask

    task automatic test_priority_order;
        int n;
        int got[4];
        int expd[4];
        logic [3:0] done;
        expd = '{1, 3, 0, 2};
        n = 0;
        do_reset();
        req_ren  = 4'hF;
        ramstate = ACCESS;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge CLK);
            done = ~req_wait;
            for (int i = 0; i < 4; i++) if (done[i] && n < 4) begin got[n] = i; n++; end
            step();
            req_ren = req_ren & ~done;
        end
        total++; if (n != 4) begin bad++; $display("FAIL order_timeout got=%0d want=4", n); end
        for (int k = 0; k < n; k++) begin
            total++; if (got[k] != expd[k]) begin bad++; $display("FAIL order_slot%0d got=%0d want=%0d", k, got[k], expd[k]); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_aging;
        int n;
        int i0_pos;
        int got[8];
        logic [3:0] done;
        n = 0;
        i0_pos = 0;
        do_reset();
        req_ren  = 4'b1011;
        ramstate = ACCESS;
        for (int c = 0; c < 40 && i0_pos == 0; c++) begin
            @(negedge CLK);
            done = ~req_wait;
            for (int i = 0; i < 4; i++) if (done[i] && n < 8) begin
                got[n] = i;
                n++;
                if (i == 0) i0_pos = n;
            end
            step();
            req_ren[0] = req_ren[0] & ~done[0];
        end
        total++; if (i0_pos != 5) begin bad++; $display("FAIL aging_i0_pick got=%0d want=5", i0_pos); end
        total++; if (n < 4 || got[0] != 1 || got[1] != 3 || got[2] != 1 || got[3] != 3) begin
            bad++; $display("FAIL aging_data_alt got=%0d,%0d,%0d,%0d want=1,3,1,3", got[0], got[1], got[2], got[3]);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_lock;
        int n;
        int got[4];
        int stamp[4];
        int cnt[4];
        logic [3:0] done;
        n = 0;
        cnt = '{0, 0, 0, 0};
        do_reset();
        req_ren     = 4'b1010;
        req_lock[1] = 1'b1;
        ramstate    = ACCESS;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge CLK);
            done = ~req_wait;
            for (int i = 0; i < 4; i++) if (done[i] && n < 4) begin
                got[n] = i; stamp[n] = c; n++; cnt[i]++;
            end
            step();
            if (cnt[1] >= 3) req_ren[1] = 1'b0;
            if (cnt[3] >= 1) req_ren[3] = 1'b0;
        end
        total++; if (n != 4 || got[0] != 1 || got[1] != 1 || got[2] != 3 || got[3] != 1) begin
            bad++; $display("FAIL lock_order got n=%0d %0d,%0d,%0d,%0d want 4 1,1,3,1", n, got[0], got[1], got[2], got[3]);
        end
        total++; if (stamp[1] != stamp[0] + 1) begin bad++; $display("FAIL lock_back_to_back got=%0d want=%0d", stamp[1], stamp[0] + 1); end
        total++; if (stamp[2] != stamp[1] + 2) begin bad++; $display("FAIL lock_release_gap got=%0d want=%0d", stamp[2], stamp[1] + 2); end
        idle_inputs();
        step();
    endtask

    task automatic test_write_wins;
        idle_inputs();
        step();
        req_ren[3]   = 1'b1;
        req_wen[3]   = 1'b1;
        req_store[3] = 32'hDEAD;
        req_addr[3]  = 32'h80;
        ramstate     = BUSY;
        step(); @(negedge CLK);
        total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin bad++; $display("FAIL write_en got wen=%b ren=%b want wen=1 ren=0", ramWEN, ramREN); end
        total++; if (ramstore !== 32'hDEAD || ramaddr !== 32'h80) begin bad++; $display("FAIL write_bus got store=%h addr=%h want dead/80", ramstore, ramaddr); end
        total++; if (grant_id !== REQ_D1) begin bad++; $display("FAIL write_owner got=%0d want=3", grant_id); end
        step();
        ramstate = ACCESS;
        @(negedge CLK);
        total++; if (req_wait !== 4'b0111) begin bad++; $display("FAIL write_done got=%b want=0111", req_wait); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_abort;
        req_ren[2]  = 1'b1;
        req_addr[2] = 32'h100;
        ramstate    = BUSY;
        step(); @(negedge CLK);
        total++; if (grant_vld !== 1'b1 || grant_id !== REQ_I1 || ramREN !== 1'b1) begin
            bad++; $display("FAIL abort_grant got vld=%b id=%0d ren=%b want 1 2 1", grant_vld, grant_id, ramREN);
        end
        step();
        req_ren[2] = 1'b0;
        ramstate   = ACCESS;
        @(negedge CLK);
        total++; if (req_wait !== 4'hF || ramREN !== 1'b0) begin bad++; $display("FAIL abort_no_pulse got wait=%b ren=%b want 1111 0", req_wait, ramREN); end
        step();
        ramstate = FREE;
        @(negedge CLK);
        total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b want=0", grant_vld); end
        step();
    endtask

    task automatic test_reset_mid_busy;
        idle_inputs();
        req_ren[1] = 1'b1;
        ramstate   = ACCESS;
        step(); @(negedge CLK);
        step();
        req_ren[1] = 1'b0;
        ramstate   = BUSY;
        step();
        req_ren[1] = 1'b1;
        step(); @(negedge CLK);
        total++; if (grant_vld !== 1'b1 || grant_id !== REQ_D0) begin bad++; $display("FAIL rst_pre_busy got vld=%b id=%0d want 1 1", grant_vld, grant_id); end
        #1 nRST = 1'b0;
        #1;
        total++; if (grant_vld !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL rst_async_grant got vld=%b id=%0d want 0 0", grant_vld, grant_id); end
        total++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || req_wait !== 4'hF) begin
            bad++; $display("FAIL rst_async_ram got ren=%b addr=%h wait=%b want 0 0 1111", ramREN, ramaddr, req_wait);
        end
        step();
        nRST       = 1'b1;
        req_ren[3] = 1'b1;
        step(); @(negedge CLK);
        total++; if (grant_id !== REQ_D0) begin bad++; $display("FAIL rst_ptr_zero got=%0d want=1", grant_id); end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority_order();
        test_aging();
        test_lock();
        test_write_wins();
        test_abort();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
